dds_sweep_controller: RTL and testbench
=======================================

// Module: dds_sweep_controller
// PURPOSE
//  Sequences the DDS datapath's frequency word over time: linear up/down, sawtooth or triangle sweeps of phase_M.
//  Also applies amplitude and waveform shape from a one-shot configuration.
//  Sits between the configuration source and phase_accumulator / phase_to_amplitude / amplitude_control,
//  on the 1 MHz datapath clock.
// PARAMETERS
//  M_W      10  width of frequency tuning word phase_M
//  A_W      11  width of amplitude word signal_A (mV)
//  DWELL_W  16  width of dwell counter
// PORTS
//  clk           in   1        datapath clock (1 MHz domain)
//  rst           in   1        reset, asynchronous, active-low
//  cfg_valid     in   1        configuration offered
//  cfg_ready     out  1        configuration accepted when cfg_valid&cfg_ready
//  cfg_start_m   in   M_W      sweep start tuning word
//  cfg_stop_m    in   M_W      sweep stop tuning word
//  cfg_step_m    in   M_W      step magnitude per update (0 treated as 1)
//  cfg_dwell     in   DWELL_W  each value held cfg_dwell+1 cycles
//  cfg_mode      in   2        0 single, 1 sawtooth repeat, 2 triangle, 3 = single
//  cfg_shape     in   2        waveform shape forwarded to signal_shape
//  cfg_amp       in   A_W      amplitude forwarded to signal_A
//  run           in   1        level: start (IDLE) / continue (SWEEP); low in SWEEP = pause
//  abort         in   1        stop immediately, mute
//  phase_M       out  M_W      tuning word to phase accumulator (registered)
//  signal_A      out  A_W      amplitude to amplitude_control (registered)
//  signal_shape  out  2        shape to phase_to_amplitude (registered)
//  m_update      out  1        1-cycle pulse in the first cycle a new phase_M is visible
//  busy          out  1        high in SWEEP
//  sweep_done    out  1        1-cycle pulse on completion of a single sweep
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; phase_M=0, signal_A=0, signal_shape=0, m_update=0, busy=0,
//    sweep_done=0, cfg_loaded=0. cfg_ready=1 after reset (combinational: state==IDLE).
//  Config:
//    - Accepted only in IDLE; latched into shadow regs; sets cfg_loaded.
//    - Outputs are not changed by a config write.
//    - Outputs are never affected by cfg_* inputs outside acceptance.
//  IDLE->SWEEP: run=1 & cfg_loaded (value at cycle start) & !abort. Next edge:
//    - phase_M=start, signal_A=amp, signal_shape=shape, m_update=1, busy=1.
//    - Dwell counter loaded with cfg_dwell.
//    - Direction dir_up = (stop>=start).
//  Cfg accept and run in the same IDLE cycle: config latched; run acts on the following cycle.
//  SWEEP, run=1:
//    - Counter decrements.
//    - At counter==0, the next edge applies the update (below) and reloads the counter.
//    - Each value is held exactly cfg_dwell+1 cycles.
//  SWEEP, run=0: counter and outputs frozen; busy stays 1.
//  Update arithmetic:
//    - Computed in M_W+1 bits.
//    - next = cur+step (dir_up) or cur-step. If next passes or equals the leg target, next=target (clamp).
//    - No wrap-around ever occurs.
//  At target (cur==target when counter==0):
//    - mode 0/3: -> DONE; phase_M unchanged, no m_update.
//    - mode 1: phase_M=start, m_update=1.
//    - mode 2: dir flips; target swaps between stop and start; first step taken away from the endpoint.
//  start==stop:
//    - mode 0/3: DONE after one dwell.
//    - mode 1/2: hold forever, no m_update until abort.
//  DONE: 1 cycle; sweep_done=1, busy=0; outputs keep final values; -> IDLE. cfg_loaded kept.
//  abort=1 (any state, highest priority): next edge -> IDLE.
//    - phase_M=0, signal_A=0, busy=0, m_update=0.
//    - sweep_done not pulsed; signal_shape kept.
//  Reset mid-sweep: immediate return to reset values.
//  Latency: run sample -> phase_M=start is 1 edge. Counter hitting 0 -> new phase_M is 1 edge.
// TESTING
//  1. Config start=10, stop=40, step=10, dwell=2, mode0; run=1
//     -> phase_M 10,20,30,40, each held 3 cycles; 4 m_update pulses; sweep_done 1 cycle after last hold; busy low.
//  2. start=100, stop=95, step=3, dwell=0, mode0 -> phase_M 100,97,95 (clamped); sweep_done once.
//  3. start=0, stop=4, step=2, dwell=0, mode2 -> phase_M 0,2,4,2,0,2,4...; no sweep_done; abort -> phase_M=0, signal_A=0 next edge.
//  4. mode1 start=5, stop=7, step=1 -> phase_M 5,6,7,5,6; drop run 3 cycles mid-hold -> value and counter frozen, then resume.
//  5. start=1023, stop=1023, step=0, mode0 (M_W=10) -> no overflow; DONE after dwell+1 cycles.
//  6. Edge cases: cfg_valid during SWEEP -> cfg_ready=0, config ignored; async rst low mid-sweep -> all outputs 0 immediately.

Source files
------------

// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller
// Steps the DDS frequency tuning word from a start value to a stop value.
// Sweeps can be single-shot, sawtooth (repeat) or triangle (bounce).
// Each value is held for a programmable dwell time.
// Amplitude and waveform shape come from the same one-shot configuration.
module dds_sweep_controller #(
  parameter int M_W     = 10,
  parameter int A_W     = 11,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [M_W-1:0]     cfg_start_m,
  input  logic [M_W-1:0]     cfg_stop_m,
  input  logic [M_W-1:0]     cfg_step_m,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [1:0]         cfg_shape,
  input  logic [A_W-1:0]     cfg_amp,
  input  logic               run,
  input  logic               abort,
  output logic [M_W-1:0]     phase_M,
  output logic [A_W-1:0]     signal_A,
  output logic [1:0]         signal_shape,
  output logic               m_update,
  output logic               busy,
  output logic               sweep_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [M_W-1:0]     STEP_ONE = M_W'(1);
  localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);

  // One step from cur toward tgt, clamped so it never passes the target.
  // The extra top bit catches both carry-out and borrow, so no wrap-around.
  function automatic logic [M_W-1:0] step_toward(input logic [M_W-1:0] cur,
                                                 input logic [M_W-1:0] step,
                                                 input logic [M_W-1:0] tgt,
                                                 input logic           up);
    logic [M_W:0] nxt;
    logic         clamp;
    if (up) begin
      nxt   = {1'b0, cur} + {1'b0, step};
      clamp = (nxt >= {1'b0, tgt});
    end else begin
      nxt   = {1'b0, cur} - {1'b0, step};
      clamp = nxt[M_W] || (nxt <= {1'b0, tgt});
    end
    if (clamp) begin
      return tgt;
    end else begin
      return nxt[M_W-1:0];
    end
  endfunction

  state_e               state_q, state_d;
  logic [M_W-1:0]       start_q, stop_q, step_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [1:0]           mode_q, cfg_shape_q;
  logic [A_W-1:0]       cfg_amp_q;
  logic                 cfg_loaded_q;

  logic [M_W-1:0]       phase_q, phase_d;
  logic [A_W-1:0]       amp_q, amp_d;
  logic [1:0]           shape_q, shape_d;
  logic                 mupd_q, mupd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic [M_W-1:0]       tgt_q, tgt_d;

  logic                 cfg_accept_s;
  logic [M_W-1:0]       tgt_flip_s;
  logic [M_W-1:0]       step_next_s;
  logic [M_W-1:0]       bounce_next_s;

  assign cfg_ready     = (state_q == ST_IDLE);
  assign cfg_accept_s  = cfg_valid && cfg_ready;
  // Target of the opposite leg once a triangle sweep reaches its endpoint.
  assign tgt_flip_s    = (tgt_q == stop_q) ? start_q : stop_q;
  assign step_next_s   = step_toward(phase_q, step_q, tgt_q, dir_q);
  assign bounce_next_s = step_toward(phase_q, step_q, tgt_flip_s, ~dir_q);

  assign phase_M      = phase_q;
  assign signal_A     = amp_q;
  assign signal_shape = shape_q;
  assign m_update     = mupd_q;
  assign busy         = busy_q;
  assign sweep_done   = done_q;

  // Shadow configuration: captured only on an accepted handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q      <= '0;
      stop_q       <= '0;
      step_q       <= STEP_ONE;
      dwell_q      <= '0;
      mode_q       <= 2'd0;
      cfg_shape_q  <= 2'd0;
      cfg_amp_q    <= '0;
      cfg_loaded_q <= 1'b0;
    end else if (cfg_accept_s) begin
      start_q      <= cfg_start_m;
      stop_q       <= cfg_stop_m;
      step_q       <= (cfg_step_m == '0) ? STEP_ONE : cfg_step_m;
      dwell_q      <= cfg_dwell;
      mode_q       <= cfg_mode;
      cfg_shape_q  <= cfg_shape;
      cfg_amp_q    <= cfg_amp;
      cfg_loaded_q <= 1'b1;
    end
  end

  // Sweep state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      amp_q   <= '0;
      shape_q <= 2'd0;
      mupd_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b1;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      amp_q   <= amp_d;
      shape_q <= shape_d;
      mupd_q  <= mupd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state and output logic; abort overrides everything and mutes.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    amp_d   = amp_q;
    shape_d = shape_q;
    mupd_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    if (abort) begin
      state_d = ST_IDLE;
      phase_d = '0;
      amp_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A config written this cycle is only usable from the next cycle.
          if (run && cfg_loaded_q && !cfg_accept_s) begin
            state_d = ST_SWEEP;
            phase_d = start_q;
            amp_d   = cfg_amp_q;
            shape_d = cfg_shape_q;
            mupd_d  = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = dwell_q;
            dir_d   = (stop_q >= start_q);
            tgt_d   = stop_q;
          end else begin
            busy_d = 1'b0;
          end
        end
        ST_SWEEP: begin
          if (!run) begin
            cnt_d = cnt_q;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            cnt_d = dwell_q;
            if (phase_q != tgt_q) begin
              phase_d = step_next_s;
              mupd_d  = 1'b1;
            end else begin
              case (mode_q)
                2'd1: begin
                  if (start_q != stop_q) begin
                    phase_d = start_q;
                    mupd_d  = 1'b1;
                  end else begin
                    phase_d = phase_q;
                  end
                end
                2'd2: begin
                  if (start_q != stop_q) begin
                    dir_d   = ~dir_q;
                    tgt_d   = tgt_flip_s;
                    phase_d = bounce_next_s;
                    mupd_d  = 1'b1;
                  end else begin
                    phase_d = phase_q;
                  end
                end
                default: begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                end
              endcase
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Directed testbench for dds_sweep_controller.
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge.
module tb_dds_sweep_controller;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [9:0]  cfg_start_m;
  logic [9:0]  cfg_stop_m;
  logic [9:0]  cfg_step_m;
  logic [15:0] cfg_dwell;
  logic [1:0]  cfg_mode;
  logic [1:0]  cfg_shape;
  logic [10:0] cfg_amp;
  logic        run;
  logic        abort;
  logic [9:0]  phase_M;
  logic [10:0] signal_A;
  logic [1:0]  signal_shape;
  logic        m_update;
  logic        busy;
  logic        sweep_done;

  int tests_run;
  int tests_failed;

  dds_sweep_controller #(.M_W(10), .A_W(11), .DWELL_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_start_m  (cfg_start_m),
    .cfg_stop_m   (cfg_stop_m),
    .cfg_step_m   (cfg_step_m),
    .cfg_dwell    (cfg_dwell),
    .cfg_mode     (cfg_mode),
    .cfg_shape    (cfg_shape),
    .cfg_amp      (cfg_amp),
    .run          (run),
    .abort        (abort),
    .phase_M      (phase_M),
    .signal_A     (signal_A),
    .signal_shape (signal_shape),
    .m_update     (m_update),
    .busy         (busy),
    .sweep_done   (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one configuration for a single cycle; call and return on a falling edge.
  task automatic do_config(input logic [9:0] s, input logic [9:0] e, input logic [9:0] st,
                           input logic [15:0] dw, input logic [1:0] md, input logic [1:0] sh,
                           input logic [10:0] am);
    cfg_start_m = s;
    cfg_stop_m  = e;
    cfg_step_m  = st;
    cfg_dwell   = dw;
    cfg_mode    = md;
    cfg_shape   = sh;
    cfg_amp     = am;
    cfg_valid   = 1'b1;
    @(negedge clk);
    cfg_valid   = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (phase_M !== 10'd0 || signal_A !== 11'd0 || signal_shape !== 2'd0 || m_update !== 1'b0 ||
        busy !== 1'b0 || sweep_done !== 1'b0 || cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_values: phase_M=%0d signal_A=%0d shape=%0d m_update=%b busy=%b done=%b cfg_ready=%b, expected 0 0 0 0 0 0 1",
               phase_M, signal_A, signal_shape, m_update, busy, sweep_done, cfg_ready);
    end
    // Without any loaded configuration, run must not start a sweep.
    run = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || m_update !== 1'b0 || phase_M !== 10'd0) begin
      tests_failed++;
      $display("FAIL run_without_cfg: busy=%b m_update=%b phase_M=%0d, expected 0 0 0", busy, m_update, phase_M);
    end
    run = 1'b0;
  endtask

  task automatic test_up_sweep();
    logic [9:0] e_ph;
    do_config(10'd10, 10'd40, 10'd10, 16'd2, 2'd0, 2'd1, 11'd1000);
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e_ph = 10'(10 * (i / 3 + 1));
      tests_run++;
      if (phase_M !== e_ph || m_update !== (i % 3 == 0) || busy !== 1'b1 || sweep_done !== 1'b0 ||
          signal_A !== 11'd1000 || signal_shape !== 2'd1) begin
        tests_failed++;
        $display("FAIL up_sweep[%0d]: phase_M=%0d m_update=%b busy=%b done=%b A=%0d shape=%0d, expected %0d %b 1 0 1000 1",
                 i, phase_M, m_update, busy, sweep_done, signal_A, signal_shape, e_ph, (i % 3 == 0));
      end
    end
    @(negedge clk);
    run = 1'b0;
    tests_run++;
    if (sweep_done !== 1'b1 || busy !== 1'b0 || phase_M !== 10'd40 || m_update !== 1'b0) begin
      tests_failed++;
      $display("FAIL up_sweep_done: done=%b busy=%b phase_M=%0d m_update=%b, expected 1 0 40 0",
               sweep_done, busy, phase_M, m_update);
    end
    @(negedge clk);
    tests_run++;
    if (sweep_done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || phase_M !== 10'd40) begin
      tests_failed++;
      $display("FAIL up_sweep_idle: done=%b busy=%b cfg_ready=%b phase_M=%0d, expected 0 0 1 40",
               sweep_done, busy, cfg_ready, phase_M);
    end
  endtask

  task automatic test_down_clamp();
    logic [9:0] e_ph [3];
    e_ph = '{10'd100, 10'd97, 10'd95};
    // run already high while the config is written: start waits one cycle.
    run = 1'b1;
    do_config(10'd100, 10'd95, 10'd3, 16'd0, 2'd3, 2'd2, 11'd300);
    tests_run++;
    if (busy !== 1'b0 || phase_M !== 10'd40) begin
      tests_failed++;
      $display("FAIL cfg_and_run_same_cycle: busy=%b phase_M=%0d, expected 0 40", busy, phase_M);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (phase_M !== e_ph[i] || m_update !== 1'b1 || busy !== 1'b1 || sweep_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL down_clamp[%0d]: phase_M=%0d m_update=%b busy=%b done=%b, expected %0d 1 1 0",
                 i, phase_M, m_update, busy, sweep_done, e_ph[i]);
      end
    end
    @(negedge clk);
    run = 1'b0;
    tests_run++;
    if (sweep_done !== 1'b1 || busy !== 1'b0 || phase_M !== 10'd95) begin
      tests_failed++;
      $display("FAIL down_clamp_done: done=%b busy=%b phase_M=%0d, expected 1 0 95", sweep_done, busy, phase_M);
    end
    @(negedge clk);
    tests_run++;
    if (sweep_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL down_clamp_single_pulse: done=%b, expected 0", sweep_done);
    end
  endtask

  task automatic test_triangle_abort();
    logic [9:0] e_ph [7];
    e_ph = '{10'd0, 10'd2, 10'd4, 10'd2, 10'd0, 10'd2, 10'd4};
    do_config(10'd0, 10'd4, 10'd2, 16'd0, 2'd2, 2'd2, 11'd500);
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      tests_run++;
      if (phase_M !== e_ph[i] || m_update !== 1'b1 || busy !== 1'b1 || sweep_done !== 1'b0 ||
          signal_A !== 11'd500) begin
        tests_failed++;
        $display("FAIL triangle[%0d]: phase_M=%0d m_update=%b busy=%b done=%b A=%0d, expected %0d 1 1 0 500",
                 i, phase_M, m_update, busy, sweep_done, signal_A, e_ph[i]);
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    run   = 1'b0;
    tests_run++;
    if (phase_M !== 10'd0 || signal_A !== 11'd0 || busy !== 1'b0 || m_update !== 1'b0 ||
        sweep_done !== 1'b0 || signal_shape !== 2'd2 || cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL triangle_abort: phase_M=%0d A=%0d busy=%b m_update=%b done=%b shape=%0d cfg_ready=%b, expected 0 0 0 0 0 2 1",
               phase_M, signal_A, busy, m_update, sweep_done, signal_shape, cfg_ready);
    end
  endtask

  task automatic test_sawtooth_pause();
    logic [9:0] e_ph [5];
    logic [9:0] r_ph [8];
    logic       r_mu [8];
    e_ph = '{10'd5, 10'd5, 10'd5, 10'd6, 10'd6};
    r_ph = '{10'd6, 10'd7, 10'd7, 10'd7, 10'd5, 10'd5, 10'd5, 10'd6};
    r_mu = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_config(10'd5, 10'd7, 10'd1, 16'd2, 2'd1, 2'd0, 11'd200);
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (phase_M !== e_ph[i] || m_update !== (i % 3 == 0) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL sawtooth[%0d]: phase_M=%0d m_update=%b busy=%b, expected %0d %b 1",
                 i, phase_M, m_update, busy, e_ph[i], (i % 3 == 0));
      end
    end
    // Pause for three cycles in the middle of the hold of value 6.
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (phase_M !== 10'd6 || m_update !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL pause[%0d]: phase_M=%0d m_update=%b busy=%b, expected 6 0 1", i, phase_M, m_update, busy);
      end
    end
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (phase_M !== r_ph[i] || m_update !== r_mu[i] || busy !== 1'b1 || sweep_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL resume[%0d]: phase_M=%0d m_update=%b busy=%b done=%b, expected %0d %b 1 0",
                 i, phase_M, m_update, busy, sweep_done, r_ph[i], r_mu[i]);
      end
    end
    abort = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_max_equal();
    do_config(10'd1023, 10'd1023, 10'd0, 16'd1, 2'd0, 2'd3, 11'd2047);
    run = 1'b1;
    @(negedge clk);
    tests_run++;
    if (phase_M !== 10'd1023 || m_update !== 1'b1 || busy !== 1'b1 || signal_A !== 11'd2047) begin
      tests_failed++;
      $display("FAIL max_equal_start: phase_M=%0d m_update=%b busy=%b A=%0d, expected 1023 1 1 2047",
               phase_M, m_update, busy, signal_A);
    end
    @(negedge clk);
    tests_run++;
    if (phase_M !== 10'd1023 || m_update !== 1'b0 || busy !== 1'b1 || sweep_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_equal_hold: phase_M=%0d m_update=%b busy=%b done=%b, expected 1023 0 1 0",
               phase_M, m_update, busy, sweep_done);
    end
    @(negedge clk);
    run = 1'b0;
    tests_run++;
    if (phase_M !== 10'd1023 || sweep_done !== 1'b1 || busy !== 1'b0 || m_update !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_equal_done: phase_M=%0d done=%b busy=%b m_update=%b, expected 1023 1 0 0",
               phase_M, sweep_done, busy, m_update);
    end
    @(negedge clk);
  endtask

  task automatic test_cfg_in_sweep();
    logic [9:0] e_ph [3];
    e_ph = '{10'd20, 10'd25, 10'd30};
    do_config(10'd20, 10'd30, 10'd5, 16'd0, 2'd0, 2'd1, 11'd100);
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (phase_M !== e_ph[i] || cfg_ready !== 1'b0 || signal_A !== 11'd100 || signal_shape !== 2'd1) begin
        tests_failed++;
        $display("FAIL cfg_in_sweep[%0d]: phase_M=%0d cfg_ready=%b A=%0d shape=%0d, expected %0d 0 100 1",
                 i, phase_M, cfg_ready, signal_A, signal_shape, e_ph[i]);
      end
      cfg_start_m = 10'd200;
      cfg_stop_m  = 10'd300;
      cfg_amp     = 11'd7;
      cfg_shape   = 2'd3;
      cfg_valid   = (i < 2);
    end
    @(negedge clk);
    run       = 1'b0;
    cfg_valid = 1'b0;
    tests_run++;
    if (sweep_done !== 1'b1 || phase_M !== 10'd30) begin
      tests_failed++;
      $display("FAIL cfg_in_sweep_done: done=%b phase_M=%0d, expected 1 30", sweep_done, phase_M);
    end
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    tests_run++;
    if (phase_M !== 10'd20 || signal_A !== 11'd100 || signal_shape !== 2'd1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL cfg_ignored_restart: phase_M=%0d A=%0d shape=%0d busy=%b, expected 20 100 1 1",
               phase_M, signal_A, signal_shape, busy);
    end
    abort = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    do_config(10'd50, 10'd60, 10'd1, 16'd3, 2'd0, 2'd2, 11'd600);
    run = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || phase_M !== 10'd51) begin
      tests_failed++;
      $display("FAIL pre_reset_sweep: busy=%b phase_M=%0d, expected 1 51", busy, phase_M);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (phase_M !== 10'd0 || signal_A !== 11'd0 || signal_shape !== 2'd0 || m_update !== 1'b0 ||
        busy !== 1'b0 || sweep_done !== 1'b0 || cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: phase_M=%0d A=%0d shape=%0d m_update=%b busy=%b done=%b cfg_ready=%b, expected 0 0 0 0 0 0 1",
               phase_M, signal_A, signal_shape, m_update, busy, sweep_done, cfg_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    // The loaded flag is cleared by reset, so run alone cannot restart.
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || phase_M !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_clears_cfg: busy=%b phase_M=%0d, expected 0 0", busy, phase_M);
    end
    run = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    cfg_valid    = 1'b0;
    cfg_start_m  = 10'd0;
    cfg_stop_m   = 10'd0;
    cfg_step_m   = 10'd0;
    cfg_dwell    = 16'd0;
    cfg_mode     = 2'd0;
    cfg_shape    = 2'd0;
    cfg_amp      = 11'd0;
    run          = 1'b0;
    abort        = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_up_sweep();
    test_down_clamp();
    test_triangle_abort();
    test_sawtooth_pause();
    test_max_equal();
    test_cfg_in_sweep();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
